sound_arbiter: RTL and testbench
================================

# sound_arbiter

Shares the single tone-generator datapath (notes/octave-shift into the sound top) between three requesters: free-play keyboard, song auto-play sequencer, and system prompt beeper. Fixed-priority arbiter with minimum-ownership preemption guard and a silent gap on every ownership change, which suppresses clicks. Sits between the mode blocks and the sound top; all outputs are registered.

## Interface
- GAP_CYCLES, 50000: silent cycles inserted before any grant; must be ≥1.
- MIN_HOLD, 1000000: cycles an owner keeps the grant before a higher-priority requester may preempt it.
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  3  request per requester; [2] beeper (highest), [1] auto-play, [0] free-play (lowest)
- notes0/notes1/notes2  in  8 each  requester note vectors, one bit per key
- shift0/shift1/shift2  in  2 each  requester octave shift (00 centre, 01 low, 10 high)
- gnt  out  3  one-hot grant; 000 when nobody owns
- notes_out  out  8  notes to sound top
- shift_out  out  2  octave to sound top
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, GAP, OWN. Registers: owner index (2 bits), gap counter, hold counter.
- Reset values: state IDLE, gnt=000, notes_out=0, shift_out=00, busy=0, both counters 0.
- IDLE: if req≠0, go to GAP with the gap counter loaded to GAP_CYCLES−1.
- GAP: gnt=000, notes_out=0, shift_out=00. Decrement each cycle. At count 0, pick the highest-priority set req bit:
  - if one exists, go to OWN with owner = that index and the hold counter cleared;
  - if none exists, go to IDLE.
  - Requests rising or falling during GAP are resolved only at GAP end.
- OWN: gnt=onehot(owner); notes_out/shift_out = registered copy of that owner's notes/shift. The hold counter increments and saturates at MIN_HOLD.
- Leaving OWN, evaluated every cycle in this order:
  1. req[owner]=0: go to GAP, or to IDLE if req=0. Outputs are zeroed on the next edge.
  2. A higher-priority req bit is set and hold counter ≥ MIN_HOLD: preempt, go to GAP.
  3. Otherwise stay in OWN. Lower-priority requests never preempt.
- Simultaneous release by the owner and a new higher request: rule 1 applies. The GAP-end pick then selects the higher requester.
- Inputs of non-owners are ignored entirely.
- Reset mid-operation returns all state and outputs to reset values immediately (asynchronous).

## Timing
- IDLE, req sampled high at edge t: busy=1 after t+1. gnt and owner data appear after edge t+1+GAP_CYCLES.
- In OWN, notes_out follows the owner's notes with exactly 1-cycle latency.
- Owner drops req at edge t: gnt=000 and notes_out=0 after edge t+1.
- Earliest preemption: the edge at which the hold counter equals MIN_HOLD, i.e. MIN_HOLD+1 cycles after the grant edge.
- Back-to-back switch: the silent window between two owners is exactly GAP_CYCLES cycles.
- Counters are sized to $clog2 of their parameter + 1; no wrap-around is possible.

## Configuration
- SOUND_ARB_GAP_EN defined: GAP state exists as described above.
- SOUND_ARB_GAP_EN undefined: GAP is removed entirely.
  - Every transition into GAP instead performs the GAP-end pick in the same cycle.
  - Grant follows req with 1-cycle latency.
  - An owner switch is direct, with no silent cycles.
  - GAP_CYCLES is ignored.

## Test plan
All scenarios use GAP_CYCLES=4, MIN_HOLD=8 and the macro defined unless stated.
- Reset: assert rst_n=0 mid-OWN -> gnt=000, notes_out=0, shift_out=00, busy=0 asynchronously.
- Single request: req=001, notes0=0x81, shift0=10 at edge 0 -> gnt=001, notes_out=0x81, shift_out=10 after edge 5; notes0 changes to 0x02 -> notes_out=0x02 one cycle later.
- Preemption guard: owner=0; set req[2] 3 cycles after grant -> no switch until hold=8; then 4 silent cycles; then gnt=100, notes_out=notes2.
- No low preemption / release handoff: owner=2 with req[0] pending -> gnt stays 100; drop req[2] -> 4 cycles of gnt=000, notes_out=0, then gnt=001.
- Request withdrawn during GAP: req=010 then req=000 within the gap -> return to IDLE, busy=0, gnt never asserts.
- Macro undefined: req=001 at edge 0 -> gnt=001 after edge 1; switching to req=100 after MIN_HOLD -> gnt=100 on the very next edge with no zero cycle.

Source files
------------

// File: rtl/sound_arbiter.sv
// Fixed-priority owner arbiter for the shared tone datapath (beeper > auto-play > free-play).
// Define SOUND_ARB_GAP_EN to insert a silent GAP of GAP_CYCLES before every grant.
module sound_arbiter #(
  parameter int unsigned GAP_CYCLES = 50000,
  parameter int unsigned MIN_HOLD   = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic [7:0] notes0,
  input  logic [7:0] notes1,
  input  logic [7:0] notes2,
  input  logic [1:0] shift0,
  input  logic [1:0] shift1,
  input  logic [1:0] shift2,
  output logic [2:0] gnt,
  output logic [7:0] notes_out,
  output logic [1:0] shift_out,
  output logic       busy
);

  localparam int unsigned HW = $clog2(MIN_HOLD) + 1;
  localparam logic [HW-1:0] HOLD_SAT = HW'(MIN_HOLD);

  if (GAP_CYCLES < 1) begin : g_gap_chk
    $error("sound_arbiter: GAP_CYCLES must be >= 1");
  end

`ifdef SOUND_ARB_GAP_EN
  localparam int unsigned GW = $clog2(GAP_CYCLES) + 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);
  typedef enum logic [1:0] {IDLE = 2'd0, GAP = 2'd1, OWN = 2'd2} state_t;
  logic [GW-1:0] r_gap;
  logic          w_go_gap;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd2} state_t;
`endif

  state_t        r_state;
  logic [1:0]    r_owner;
  logic [HW-1:0] r_hold;
  logic [2:0]    r_gnt;
  logic [7:0]    r_notes;
  logic [1:0]    r_shift;
  logic          r_busy;

  logic       w_any;
  logic [1:0] w_pick;
  logic [7:0] w_pick_notes;
  logic [1:0] w_pick_shift;
  logic [7:0] w_own_notes;
  logic [1:0] w_own_shift;
  logic       w_own_req;
  logic       w_higher;
  logic       w_hold_done;
  logic       w_switch;
  logic       w_go_grant;
  logic       w_go_idle;

  assign w_any       = |req;
  assign w_hold_done = (r_hold >= HOLD_SAT);

  always_comb begin
    w_pick = 2'd0;
    if (req[2])      w_pick = 2'd2;
    else if (req[1]) w_pick = 2'd1;
  end

  always_comb begin
    w_pick_notes = '0;
    w_pick_shift = '0;
    case (w_pick)
      2'd0:    begin w_pick_notes = notes0; w_pick_shift = shift0; end
      2'd1:    begin w_pick_notes = notes1; w_pick_shift = shift1; end
      2'd2:    begin w_pick_notes = notes2; w_pick_shift = shift2; end
      default: ;
    endcase
  end

  always_comb begin
    w_own_notes = '0;
    w_own_shift = '0;
    w_own_req   = 1'b0;
    w_higher    = 1'b0;
    case (r_owner)
      2'd0: begin
        w_own_notes = notes0; w_own_shift = shift0;
        w_own_req   = req[0]; w_higher    = req[2] | req[1];
      end
      2'd1: begin
        w_own_notes = notes1; w_own_shift = shift1;
        w_own_req   = req[1]; w_higher    = req[2];
      end
      2'd2: begin
        w_own_notes = notes2; w_own_shift = shift2;
        w_own_req   = req[2]; w_higher    = 1'b0;
      end
      default: ;
    endcase
  end

  // w_switch marks every ownership change; with the gap enabled it enters GAP,
  // otherwise the GAP-end pick is taken in the same cycle.
  always_comb begin
    w_switch   = 1'b0;
    w_go_grant = 1'b0;
    w_go_idle  = 1'b0;
    case (r_state)
      IDLE: w_switch = w_any;
`ifdef SOUND_ARB_GAP_EN
      GAP: begin
        if (r_gap == '0) begin
          w_go_grant = w_any;
          w_go_idle  = ~w_any;
        end
      end
`endif
      OWN: begin
        if (!w_own_req) begin
          w_switch  = w_any;
          w_go_idle = ~w_any;
        end else begin
          w_switch  = w_higher & w_hold_done;
        end
      end
      default: ;
    endcase
`ifdef SOUND_ARB_GAP_EN
    w_go_gap = w_switch;
`else
    w_go_grant = w_switch;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_hold  <= '0;
`ifdef SOUND_ARB_GAP_EN
      r_gap   <= '0;
`endif
      r_gnt   <= '0;
      r_notes <= '0;
      r_shift <= '0;
      r_busy  <= 1'b0;
    end else if (w_go_grant) begin
      r_state <= OWN;
      r_owner <= w_pick;
      r_hold  <= '0;
      r_gnt   <= 3'b001 << w_pick;
      r_notes <= w_pick_notes;
      r_shift <= w_pick_shift;
      r_busy  <= 1'b1;
`ifdef SOUND_ARB_GAP_EN
    end else if (w_go_gap) begin
      r_state <= GAP;
      r_gap   <= GAP_LOAD;
      r_gnt   <= '0;
      r_notes <= '0;
      r_shift <= '0;
      r_busy  <= 1'b1;
`endif
    end else if (w_go_idle) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_notes <= '0;
      r_shift <= '0;
      r_busy  <= 1'b0;
    end else begin
`ifdef SOUND_ARB_GAP_EN
      if (r_state == GAP) r_gap <= r_gap - 1'b1;
`endif
      if (r_state == OWN) begin
        if (r_hold != HOLD_SAT) r_hold <= r_hold + 1'b1;
        r_notes <= w_own_notes;
        r_shift <= w_own_shift;
      end
    end
  end

  assign gnt       = r_gnt;
  assign notes_out = r_notes;
  assign shift_out = r_shift;
  assign busy      = r_busy;

endmodule

// File: tb/tb_sound_arbiter.sv
// Bench for sound_arbiter: directed scenario tasks plus a per-cycle reference scoreboard.
// Expected gap length follows SOUND_ARB_GAP_EN (4 cycles when defined, none otherwise).
module tb_sound_arbiter;

  localparam int unsigned GAPC = 4;
  localparam int unsigned MH   = 8;
`ifdef SOUND_ARB_GAP_EN
  localparam int G = 4;
`else
  localparam int G = 0;
`endif
  localparam int GMAX = (G > 0) ? G : 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = '0;
  logic [7:0] notes0 = '0, notes1 = '0, notes2 = '0;
  logic [1:0] shift0 = '0, shift1 = '0, shift2 = '0;
  logic [2:0] gnt;
  logic [7:0] notes_out;
  logic [1:0] shift_out;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  sound_arbiter #(.GAP_CYCLES(GAPC), .MIN_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .notes0(notes0), .notes1(notes1), .notes2(notes2),
    .shift0(shift0), .shift1(shift1), .shift2(shift2),
    .gnt(gnt), .notes_out(notes_out), .shift_out(shift_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] g;
    logic [7:0] n;
    logic [1:0] s;
    logic       b;
  } exp_t;

  exp_t sb[$];
  int   m_st = 0;   // 0 idle, 1 silent gap, 2 owning
  int   m_own = 0;
  int   m_cnt = 0;
  int   m_hold = 0;

  function automatic logic [7:0] mnotes(input int i);
    return (i == 2) ? notes2 : (i == 1) ? notes1 : notes0;
  endfunction

  function automatic logic [1:0] mshift(input int i);
    return (i == 2) ? shift2 : (i == 1) ? shift1 : shift0;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int   top;
    exp_t e;
    if (!rst_n) begin
      m_st = 0; m_own = 0; m_cnt = 0; m_hold = 0;
      sb.delete();
    end else begin
      top = req[2] ? 2 : req[1] ? 1 : req[0] ? 0 : -1;
      case (m_st)
        0: if (top >= 0) begin
             if (G > 0) begin m_st = 1; m_cnt = G - 1; end
             else begin m_st = 2; m_own = top; m_hold = 0; end
           end
        1: if (m_cnt > 0) m_cnt--;
           else if (top >= 0) begin m_st = 2; m_own = top; m_hold = 0; end
           else m_st = 0;
        default: begin
          if (req[m_own] == 1'b0 || (top > m_own && m_hold >= MH)) begin
            if (top < 0) m_st = 0;
            else if (G > 0) begin m_st = 1; m_cnt = G - 1; end
            else begin m_own = top; m_hold = 0; end
          end else if (m_hold < MH) begin
            m_hold++;
          end
        end
      endcase
    end
    e.g = (m_st == 2) ? 3'(1 << m_own) : 3'b000;
    e.n = (m_st == 2) ? mnotes(m_own) : 8'h00;
    e.s = (m_st == 2) ? mshift(m_own) : 2'b00;
    e.b = (m_st != 0);
    sb.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t x;
    if (sb.size() != 0) begin
      x = sb.pop_front();
      n_tests++;
      if ({gnt, notes_out, shift_out, busy} !== {x.g, x.n, x.s, x.b}) begin
        n_fail++;
        $display("FAIL scoreboard @%0t: got gnt=%b notes=%h shift=%b busy=%b, expected gnt=%b notes=%h shift=%b busy=%b",
                 $time, gnt, notes_out, shift_out, busy, x.g, x.n, x.s, x.b);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(2);
    n_tests++;
    if ({gnt, notes_out, shift_out, busy} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_state: got %b, expected all zero", {gnt, notes_out, shift_out, busy});
    end
    rst_n = 1'b1;
    cyc(1);
    n_tests++;
    if ({gnt, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL idle_after_reset: gnt=%b busy=%b, expected 000/0", gnt, busy);
    end
  endtask

  task automatic test_single();
    logic [13:0] exp;
    req = 3'b001; notes0 = 8'h81; shift0 = 2'b10;
    for (int k = 1; k <= G + 1; k++) begin
      cyc(1);
      exp = (k == G + 1) ? {3'b001, 8'h81, 2'b10, 1'b1} : {3'b000, 8'h00, 2'b00, 1'b1};
      n_tests++;
      if ({gnt, notes_out, shift_out, busy} !== exp) begin
        n_fail++;
        $display("FAIL single_grant edge %0d: got %h, expected %h", k, {gnt, notes_out, shift_out, busy}, exp);
      end
    end
    notes0 = 8'h02;
    cyc(1);
    n_tests++;
    if (notes_out !== 8'h02) begin
      n_fail++;
      $display("FAIL notes_follow: got %h, expected 02", notes_out);
    end
    req = 3'b000;
    cyc(1);
    n_tests++;
    if ({gnt, notes_out, shift_out, busy} !== 14'h0) begin
      n_fail++;
      $display("FAIL release_to_idle: got %h, expected 0", {gnt, notes_out, shift_out, busy});
    end
  endtask

  task automatic test_preempt_and_handoff();
    logic [13:0] exp;
    int p;
    p = MH + 1;
    notes0 = 8'h11; shift0 = 2'b00; notes2 = 8'h44; shift2 = 2'b01;
    req = 3'b001;
    cyc(G + 1);
    n_tests++;
    if (gnt !== 3'b001) begin
      n_fail++;
      $display("FAIL preempt_setup: gnt=%b, expected 001", gnt);
    end
    cyc(3);
    req = 3'b101;
    for (int k = 4; k <= p + G; k++) begin
      cyc(1);
      exp = (k < p)     ? {3'b001, 8'h11, 2'b00, 1'b1} :
            (k < p + G) ? {3'b000, 8'h00, 2'b00, 1'b1} :
                          {3'b100, 8'h44, 2'b01, 1'b1};
      n_tests++;
      if ({gnt, notes_out, shift_out, busy} !== exp) begin
        n_fail++;
        $display("FAIL preempt_guard k=%0d: got %h, expected %h", k, {gnt, notes_out, shift_out, busy}, exp);
      end
    end
    for (int k = 0; k < 12; k++) begin
      cyc(1);
      n_tests++;
      if ({gnt, notes_out} !== {3'b100, 8'h44}) begin
        n_fail++;
        $display("FAIL no_low_preempt k=%0d: gnt=%b notes=%h, expected 100/44", k, gnt, notes_out);
      end
    end
    req = 3'b001;
    for (int k = 1; k <= G + 1; k++) begin
      cyc(1);
      exp = (k <= G) ? {3'b000, 8'h00, 2'b00, 1'b1} : {3'b001, 8'h11, 2'b00, 1'b1};
      n_tests++;
      if ({gnt, notes_out, shift_out, busy} !== exp) begin
        n_fail++;
        $display("FAIL release_handoff k=%0d: got %h, expected %h", k, {gnt, notes_out, shift_out, busy}, exp);
      end
    end
  endtask

  task automatic test_reset_mid_own();
    cyc(2);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({gnt, notes_out, shift_out, busy} !== 14'h0) begin
      n_fail++;
      $display("FAIL async_reset: got %h, expected 0", {gnt, notes_out, shift_out, busy});
    end
    req = 3'b000;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    n_tests++;
    if ({gnt, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL post_reset_idle: gnt=%b busy=%b, expected 000/0", gnt, busy);
    end
  endtask

  task automatic test_withdraw_in_gap();
    logic [2:0] eg;
    logic       eb;
    notes1 = 8'h5A; shift1 = 2'b10;
    req = 3'b010;
    for (int k = 1; k <= G + 2; k++) begin
      cyc(1);
      eg = (k == 1 && G == 0) ? 3'b010 : 3'b000;
      eb = (k <= GMAX);
      n_tests++;
      if ({gnt, busy} !== {eg, eb}) begin
        n_fail++;
        $display("FAIL withdraw_gap k=%0d: gnt=%b busy=%b, expected %b/%b", k, gnt, busy, eg, eb);
      end
      if (k == 1) req = 3'b000;
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      cyc(1);
      notes0 = 8'($urandom); notes1 = 8'($urandom); notes2 = 8'($urandom);
      shift0 = 2'($urandom_range(0, 2)); shift1 = 2'($urandom_range(0, 2));
      shift2 = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) req = 3'($urandom_range(0, 7));
    end
    req = 3'b000;
    cyc(G + 3);
  endtask

  initial begin
    test_reset();
    test_single();
    test_preempt_and_handoff();
    test_reset_mid_own();
    test_withdraw_in_gap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
